fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the synchronous instruction memory (1-cycle registered read, no enable).
//  Owns the PC, drives the memory address and tracks the single in-flight read.
//  Buffers returned words so decode back-pressure never loses an instruction.
//  Sits between imem and decode; accepts redirects (branch/jump/trap) from execute.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  BUF_DEPTH   2              skid-buffer entries; must be >=2 for 1 instr/cycle
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  fetch_en     in   1   1 = issue new reads; 0 = hold PC, drain in-flight/buffer
//  imem_addr    out  32  byte address to imem (addrIn); imem word index = addr[9:2]
//  imem_rdata   in   32  imem instrOut, valid the cycle after imem_addr was issued
//  inst_valid   out  1   head of buffer holds an instruction
//  inst_ready   in   1   decode accepts head this cycle
//  inst         out  32  instruction word at head
//  inst_pc      out  32  byte address of inst
//  redirect     in   1   flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new PC; bits [1:0] must be 0
//  fetch_err    out  1   sticky: a redirect had redirect_pc[1:0]!=0
// BEHAVIOUR
//  Reset: pc=RESET_PC, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0,
//   buffer empty, in-flight cleared. Reset mid-operation discards everything identically.
//  imem_addr = pc (direct from register, no combinational path from inputs).
//  Issue in cycle t when fetch_en & ~redirect & (count + inflight - deq) < BUF_DEPTH,
//   where deq = inst_valid & inst_ready. On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4.
//  Capture: if inflight in cycle t, imem_rdata/inflight_pc are pushed at end of t; visible t+1.
//   Credit rule guarantees the push never overflows; the unused memory output is ignored.
//  Latency: issue t -> inst_valid t+2. First valid after reset: 2 cycles after rst falls
//   (fetch_en=1). Steady state with inst_ready=1: one instruction per cycle, consecutive PCs.
//  Handshake: transfer iff inst_valid & inst_ready; inst/inst_pc stable while valid & ~ready.
//  Redirect (priority over everything): at end of cycle, buffer emptied, inflight dropped
//   (its data next cycle is not pushed), pc<={redirect_pc[31:2],2'b00}; no issue that cycle.
//   A head handshake in the redirect cycle counts as delivered; decode owns its squash.
//   redirect -> imem_addr=target next cycle -> inst_valid for target 3 cycles after redirect.
//  redirect_pc[1:0]!=0: fetch_err<=1 (sticky until rst); address still forced aligned.
//  fetch_en=0: no issue; in-flight word still captured; buffer drains normally; redirect honoured.
//  PC wraps 32'hFFFF_FFFC -> 0 with no flag. Address aliasing above 1 KB is imem's concern.
//  Simultaneous push+pop on a full buffer is legal (count unchanged).
// STRUCTURE
//  Shared package/header (riscv_defs): RESET_PC default, INSTR_W=32, NOP=32'h0000_0013.
//  Sub-module fetch_skid_buf: BUF_DEPTH x {pc,instr} FIFO with push/pop/flush/count.
//  Top: pc register, inflight flag + inflight_pc, credit/issue logic, fetch_err flag.
// TESTING
//  Reset, fetch_en=1, ready=1, mem[i]=i -> inst_pc 0,4,8.. with inst=0,1,2.., first valid rst+2.
//  Hold ready=0 for 5 cycles mid-stream -> buffer fills to 2, imem_addr frozen, no word lost/duped.
//  Redirect to 0x40 with word in flight and buffer full -> next valid inst_pc=0x40 at +3, none stale.
//  Redirect to 0x42 -> fetch_err=1 and stays 1; fetch resumes at 0x40.
//  fetch_en=0 during stream -> in-flight word delivered, then inst_valid=0; re-enable resumes at pc.
//  Assert rst mid-stream with buffer non-empty -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-path definitions: instruction width, default reset PC and the
// {pc, instr} entry carried through the fetch skid buffer.
package fetch_ctrl_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Small circular FIFO of fetched {pc, instr} entries; flush empties it in one
// cycle, and push+pop on a full buffer keeps the count unchanged.
module fetch_skid_buf
  import fetch_ctrl_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= wdata;
        wr_ptr          <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = entries[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one read per cycle to the
// registered imem while buffer credit remains, and hands words to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          deq;
  logic          issue;
  fetch_entry_t  head;
  fetch_entry_t  wdata;

  // Credit counts the in-flight word as already occupying a slot, so its
  // capture next cycle can never overflow the buffer.
  assign deq       = inst_valid & inst_ready;
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(deq);
  assign issue     = fetch_en & ~redirect & (occupancy < (CW + 1)'(BUF_DEPTH));

  assign wdata.pc    = inflight_pc;
  assign wdata.instr = imem_rdata;

  fetch_skid_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight & ~redirect),
    .pop   (deq & ~redirect),
    .flush (redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      fetch_err   <= 1'b0;
    end else if (redirect) begin
      pc       <= align_pc(redirect_pc);
      inflight <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) fetch_err <= 1'b1;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
    end
  end

  assign imem_addr  = pc;
  assign inst_valid = (count != '0);
  assign inst       = head.instr;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the fetch stream.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inf_pc;
  bit          m_inf;
  bit          m_err;
  logic [31:0] m_buf [$];
  bit          m_known = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr[9:2]];

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compareModel();
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, m_buf.size() != 0});
    checkOutput("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
    if (m_buf.size() != 0) begin
      checkOutput("inst_pc", inst_pc, m_buf[0]);
      checkOutput("inst", inst, mem[m_buf[0][9:2]]);
    end
  endtask

  // Reference: PC stream, one outstanding read, and a queue of fetched PCs
  // whose data is looked up in the memory image on delivery.
  task automatic modelAdvance();
    bit deq;
    bit issue;
    int occ;
    if (rst) begin
      m_pc  = 32'h0;
      m_inf = 0;
      m_err = 0;
      m_buf.delete();
    end else begin
      deq = (m_buf.size() != 0) && inst_ready;
      occ = m_buf.size() + int'(m_inf) - int'(deq);
      if (redirect) begin
        m_buf.delete();
        m_inf = 0;
        m_pc  = redirect_pc & 32'hFFFF_FFFC;
        if (redirect_pc[1:0] != 2'b00) m_err = 1;
      end else begin
        issue = fetch_en && (occ < 2);
        if (deq) void'(m_buf.pop_front());
        if (m_inf) m_buf.push_back(m_inf_pc);
        m_inf = issue;
        if (issue) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit en, input bit rdy,
                               input bit redir, input logic [31:0] rpc);
    rst         = r;
    fetch_en    = en;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (m_known) compareModel();
    modelAdvance();
    @(posedge clk);
    @(negedge clk);
    m_known = 1;
  endtask

  initial begin
    logic [31:0] rpc;
    bit          r, en, rdy, redir;

    for (int i = 0; i < 256; i++) mem[i] = i;

    applyStimulus(1, 0, 0, 0, 32'h0);
    applyStimulus(1, 1, 1, 0, 32'h0);
    checkOutput("reset_inst", inst, 32'h0);
    checkOutput("reset_inst_pc", inst_pc, 32'h0);
    checkOutput("reset_valid", {31'b0, inst_valid}, 32'h0);

    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 0, 32'h0);
    for (int i = 0; i < 5; i++)  applyStimulus(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++)  applyStimulus(0, 1, 1, 0, 32'h0);

    applyStimulus(0, 1, 0, 0, 32'h0);
    applyStimulus(0, 1, 0, 1, 32'h40);
    for (int i = 0; i < 6; i++)  applyStimulus(0, 1, 1, 0, 32'h0);

    for (int i = 0; i < 3; i++)  applyStimulus(0, 1, 0, 0, 32'h0);
    applyStimulus(0, 1, 1, 1, 32'h80);
    for (int i = 0; i < 5; i++)  applyStimulus(0, 1, 1, 0, 32'h0);

    applyStimulus(0, 1, 1, 1, 32'h42);
    for (int i = 0; i < 6; i++)  applyStimulus(0, 1, 1, 0, 32'h0);

    for (int i = 0; i < 5; i++)  applyStimulus(0, 0, 1, 0, 32'h0);
    for (int i = 0; i < 6; i++)  applyStimulus(0, 1, 1, 0, 32'h0);

    for (int i = 0; i < 3; i++)  applyStimulus(0, 1, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 0, 32'h0);
    checkOutput("midrst_valid", {31'b0, inst_valid}, 32'h0);
    checkOutput("midrst_inst", inst, 32'h0);
    checkOutput("midrst_inst_pc", inst_pc, 32'h0);
    checkOutput("midrst_addr", imem_addr, 32'h0);
    checkOutput("midrst_err", {31'b0, fetch_err}, 32'h0);

    applyStimulus(0, 1, 1, 1, 32'hFFFF_FFF4);
    for (int i = 0; i < 8; i++)  applyStimulus(0, 1, 1, 0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      r     = ($urandom % 64) == 0;
      en    = ($urandom % 8) != 0;
      rdy   = ($urandom % 3) != 0;
      redir = ($urandom % 16) == 0;
      case ($urandom % 4)
        0:       rpc = 32'hFFFF_FFF0 + (($urandom % 4) << 2);
        1:       rpc = $urandom;
        default: rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      applyStimulus(r, en, rdy, redir, rpc);
    end

    compareModel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
